// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, width constants and the parity helper shared by
// uart_ctrl and uart_bit_timer.
package uart_pkg;

    localparam int unsigned MAX_DATA_BITS = 9;
    localparam int unsigned IDX_W         = 4;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    function automatic int unsigned timer_width(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

    // Narrower words are zero-extended by the caller, so the padding does not affect the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: reloadable down-counter giving a one-cycle tick after a
// half-bit or full-bit period; halted until the next load.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic load_half,
    input  logic load_full,
    input  logic halt,
    output logic tick
);

    localparam int unsigned    CW   = timer_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;
    logic          active;

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            active <= 1'b0;
        end else if (load_half) begin
            count  <= HALF;
            active <= 1'b1;
        end else if (load_full) begin
            count  <= FULL;
            active <= 1'b1;
        end else if (halt) begin
            count  <= '0;
            active <= 1'b0;
        end else if (active && count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign tick = active && (count == '0);

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: parametrised full-duplex UART with valid/ready byte paths and RX
// framing/overrun pulses. Define UART_PARITY_EN to add a parity bit on both paths.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serial_rx,
    output logic                 serial_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_parity_err
);

    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    logic                 rx_meta, rx_sync, rx_armed;
    rx_state_t            rx_state;
    logic [IDX_W-1:0]     rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_tick, rx_load_half, rx_load_full, rx_halt;
`ifdef UART_PARITY_EN
    logic                 rx_par;
`endif

    always_comb begin
        rx_load_half = (rx_state == RX_IDLE) && rx_armed && !rx_sync;
        rx_load_full = 1'b0;
        rx_halt      = 1'b0;
        if (rx_tick) begin
            case (rx_state)
                RX_START: begin
                    rx_halt      = rx_sync;
                    rx_load_full = !rx_sync;
                end
                RX_STOP: rx_halt      = 1'b1;
                default: rx_load_full = 1'b1;
            endcase
        end
    end

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) rx_timer (
        .clock    (clock),
        .reset    (reset),
        .load_half(rx_load_half),
        .load_full(rx_load_full),
        .halt     (rx_halt),
        .tick     (rx_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_armed     <= 1'b0;
            rx_state     <= RX_IDLE;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par        <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_meta      <= serial_rx;
            rx_sync      <= rx_meta;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            if (rx_sync)
                rx_armed <= 1'b1;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE:
                    if (rx_load_half)
                        rx_state <= RX_START;
                RX_START:
                    if (rx_tick) begin
                        rx_idx   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end
                RX_DATA:
                    if (rx_tick) begin
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_idx == LAST_DATA) begin
`ifdef UART_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        end else begin
                            rx_idx <= rx_idx + IDX_W'(1);
                        end
                    end
`ifdef UART_PARITY_EN
                RX_PARITY:
                    if (rx_tick) begin
                        rx_par   <= rx_sync;
                        rx_state <= RX_STOP;
                    end
`endif
                RX_STOP:
                    if (rx_tick) begin
                        rx_state <= RX_IDLE;
                        // A consume in this same cycle frees the holding register.
                        if (rx_sync) begin
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= rx_shift;
                                rx_valid <= 1'b1;
                            end else begin
                                rx_overrun <= 1'b1;
                            end
                        end else begin
                            rx_frame_err <= 1'b1;
                            rx_armed     <= 1'b0;
                        end
`ifdef UART_PARITY_EN
                        if (rx_par != parity_bit(MAX_DATA_BITS'(rx_shift), PARITY_ODD))
                            rx_parity_err <= 1'b1;
`endif
                    end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

`ifndef UART_PARITY_EN
    assign rx_parity_err = 1'b0;
`endif

    tx_state_t            tx_state;
    logic [IDX_W-1:0]     tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_tick, tx_accept, tx_last, tx_load_full, tx_halt;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    always_comb begin
        tx_accept    = tx_valid && tx_ready;
        tx_last      = (tx_state == TX_STOP) && (tx_idx == LAST_STOP);
        tx_load_full = tx_accept || (tx_tick && !tx_last);
        tx_halt      = tx_tick && tx_last;
    end

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) tx_timer (
        .clock    (clock),
        .reset    (reset),
        .load_half(1'b0),
        .load_full(tx_load_full),
        .halt     (tx_halt),
        .tick     (tx_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state  <= TX_IDLE;
            tx_idx    <= '0;
            tx_shift  <= '0;
            serial_tx <= 1'b1;
            tx_ready  <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par    <= 1'b0;
`endif
        end else begin
            case (tx_state)
                TX_IDLE:
                    if (tx_accept) begin
                        tx_shift  <= tx_data;
                        serial_tx <= 1'b0;
                        tx_ready  <= 1'b0;
                        tx_state  <= TX_START;
`ifdef UART_PARITY_EN
                        tx_par    <= parity_bit(MAX_DATA_BITS'(tx_data), PARITY_ODD);
`endif
                    end
                TX_START:
                    if (tx_tick) begin
                        serial_tx <= tx_shift[0];
                        tx_shift  <= tx_shift >> 1;
                        tx_idx    <= '0;
                        tx_state  <= TX_DATA;
                    end
                TX_DATA:
                    if (tx_tick) begin
                        if (tx_idx == LAST_DATA) begin
                            tx_idx <= '0;
`ifdef UART_PARITY_EN
                            serial_tx <= tx_par;
                            tx_state  <= TX_PARITY;
`else
                            serial_tx <= 1'b1;
                            tx_state  <= TX_STOP;
`endif
                        end else begin
                            serial_tx <= tx_shift[0];
                            tx_shift  <= tx_shift >> 1;
                            tx_idx    <= tx_idx + IDX_W'(1);
                        end
                    end
`ifdef UART_PARITY_EN
                TX_PARITY:
                    if (tx_tick) begin
                        serial_tx <= 1'b1;
                        tx_state  <= TX_STOP;
                    end
`endif
                TX_STOP:
                    if (tx_tick) begin
                        if (tx_last) begin
                            tx_state <= TX_IDLE;
                            tx_ready <= 1'b1;
                        end else begin
                            tx_idx <= tx_idx + IDX_W'(1);
                        end
                    end
                default: begin
                    tx_state  <= TX_IDLE;
                    tx_ready  <= 1'b1;
                    serial_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed scoreboard bench for uart_ctrl (8 data bits, 1 stop,
// 10 clocks per bit); parity cases follow UART_PARITY_EN.
module tb_uart_ctrl;

    localparam int CPB = 10;

    localparam logic [3:0] EV_BYTE = 4'd1;
    localparam logic [3:0] EV_FERR = 4'd2;
    localparam logic [3:0] EV_OVR  = 4'd3;
    localparam logic [3:0] EV_PERR = 4'd4;

    typedef struct {
        logic [3:0] kind;
        logic [7:0] data;
    } rx_event_t;

    logic       clock, reset, serial_rx, serial_tx;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, rx_ready;
    logic       rx_frame_err, rx_overrun, rx_parity_err;

    int compared   = 0;
    int mismatched = 0;
    logic tx_mon_en = 1'b1;

    rx_event_t    rx_q[$];
    logic [10:0]  tx_q[$];

    uart_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8),
        .STOP_BITS   (1),
        .PARITY_ODD  (1'b0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .serial_rx    (serial_rx),
        .serial_tx    (serial_tx),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_parity_err(rx_parity_err)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Frame words are {stop, parity, data, start}; the parity slot is skipped on
    // the wire when parity is not built in.
    function automatic logic skip_slot(input int i);
`ifdef UART_PARITY_EN
        return 1'b0;
`else
        return i == 9;
`endif
    endfunction

    task automatic send_rx(input logic [7:0] d, input logic p,
                           input int unsigned stop_cyc, input logic stop_val);
        logic [10:0] bits;
        bits = {stop_val, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (!skip_slot(i)) begin
                serial_rx = bits[i];
                cycles((i == 10) ? stop_cyc : CPB);
            end
        end
        serial_rx = 1'b1;
    endtask

    task automatic push_rx(input logic [3:0] kind, input logic [7:0] d);
        rx_event_t e;
        e.kind = kind;
        e.data = d;
        rx_q.push_back(e);
    endtask

    task automatic send_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        cycles(1);
        tx_valid = 1'b0;
    endtask

    // RX monitor: a new byte is one whose rx_valid was not already held unconsumed.
    initial begin
        logic pv, pr;
        rx_event_t e;
        pv = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                for (int k = 1; k <= 4; k++) begin
                    logic hit;
                    logic [7:0] d;
                    d = 8'h00;
                    case (k)
                        1: begin hit = rx_valid && (!pv || pr); d = rx_data; end
                        2: hit = rx_frame_err;
                        3: hit = rx_overrun;
                        default: hit = rx_parity_err;
                    endcase
                    if (hit) begin
                        if (rx_q.size() == 0) begin
                            compared++;
                            mismatched++;
                            $display("FAIL rx_event_unexpected: actual kind %0d data 0x%0h required none", k, d);
                        end else begin
                            e = rx_q.pop_front();
                            check("rx_event", {20'h0, 4'(k), d}, {20'h0, e.kind, e.data});
                        end
                    end
                end
            end
            pv = rx_valid;
            pr = rx_ready;
        end
    end

    // TX monitor: checks both ends of every bit slot and tx_ready over the frame.
    initial begin
        logic prev;
        logic [10:0] exp;
        logic first;
        prev = 1'b1;
        forever begin
            @(negedge clock);
            if (tx_mon_en && !reset && prev && !serial_tx) begin
                if (tx_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL tx_frame_unexpected: actual start bit required idle line");
                end else begin
                    exp = tx_q.pop_front();
                    first = 1'b1;
                    for (int b = 0; b < 11; b++) begin
                        if (!skip_slot(b)) begin
                            for (int c = 0; c < CPB; c++) begin
                                if (!first) @(negedge clock);
                                first = 1'b0;
                                if (c == 0 || c == CPB - 1) begin
                                    check("tx_bit", serial_tx, exp[b]);
                                    check("tx_ready_busy", tx_ready, 1'b0);
                                end
                            end
                        end
                    end
                    @(negedge clock);
                    check("tx_ready_after", tx_ready, 1'b1);
                    check("tx_line_after", serial_tx, 1'b1);
                end
            end
            prev = serial_tx;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        serial_rx = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        rx_ready  = 1'b1;
        cycles(3);
        check("reset_serial_tx", serial_tx, 1'b1);
        check("reset_tx_ready", tx_ready, 1'b1);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_pulses", {rx_frame_err, rx_overrun, rx_parity_err}, 3'b000);
        reset = 1'b0;
        cycles(5);

        // Frame 0,1,0,1,0,1,1,0,0,1 carries 0x35.
        push_rx(EV_BYTE, 8'h35);
        send_rx(8'h35, 1'b0, CPB, 1'b1);
        cycles(20);

        // 0xA5 on the wire; a request while busy must be ignored.
        tx_q.push_back({1'b1, 1'b0, 8'hA5, 1'b0});
        send_tx(8'hA5);
        cycles(40);
        send_tx(8'h00);
        cycles(100);

        // Stop bit held low 30 cycles, then a clean 0x5A once the line is high.
        push_rx(EV_FERR, 8'h00);
        push_rx(EV_BYTE, 8'h5A);
        send_rx(8'hC3, 1'b0, 30, 1'b0);
        cycles(20);
        send_rx(8'h5A, 1'b0, CPB, 1'b1);
        cycles(20);

        // Back-to-back frames with the consumer stalled.
        rx_ready = 1'b0;
        push_rx(EV_BYTE, 8'h11);
        push_rx(EV_OVR, 8'h00);
        send_rx(8'h11, 1'b0, CPB, 1'b1);
        send_rx(8'h22, 1'b0, CPB, 1'b1);
        cycles(5);
        check("overrun_hold_valid", rx_valid, 1'b1);
        check("overrun_hold_data", rx_data, 8'h11);
        rx_ready = 1'b1;
        cycles(1);
        check("consume_clears_valid", rx_valid, 1'b0);
        cycles(20);
        check("valid_stays_low", rx_valid, 1'b0);

        // 3-cycle glitch is a false start.
        serial_rx = 1'b0;
        cycles(3);
        serial_rx = 1'b1;
        cycles(40);

        // Reset during the start bit of 0xFF.
        tx_mon_en = 1'b0;
        send_tx(8'hFF);
        cycles(4);
        check("tx_start_low", serial_tx, 1'b0);
        reset = 1'b1;
        cycles(1);
        check("abort_serial_tx", serial_tx, 1'b1);
        check("abort_tx_ready", tx_ready, 1'b1);
        reset = 1'b0;
        cycles(120);
        check("abort_line_idle", serial_tx, 1'b1);
        tx_mon_en = 1'b1;
        cycles(2);

        // 0x03: even parity bit is 0 on TX; RX sends parity 1 to force an error.
        tx_q.push_back({1'b1, 1'b0, 8'h03, 1'b0});
        send_tx(8'h03);
        cycles(130);
        push_rx(EV_BYTE, 8'h03);
`ifdef UART_PARITY_EN
        push_rx(EV_PERR, 8'h00);
`endif
        send_rx(8'h03, 1'b1, CPB, 1'b1);
        cycles(20);

        check("rx_queue_drained", rx_q.size(), 0);
        check("tx_queue_drained", tx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
